history_buffer: RTL

- Parametrised LZS-decode history engine.
- Accepts a decoded token stream: literal bytes, or back-reference copies given as (offset, length).
- Emits the reconstructed byte stream with valid/ready backpressure, and keeps a circular history window in an internal RAM with 1-cycle synchronous read.
- Sits between the LZS token parser and the output packer.

---
 rtl/history_buffer_if.sv | 29 ++
 rtl/history_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/history_buffer_if.sv
// Token-in / symbol-out bus of the LZS history engine, plus its status outputs.
interface history_buffer_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 11,
    parameter int unsigned LW = 12
);
    logic          in_valid;
    logic          in_ready;
    logic          in_is_copy;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_offset;
    logic [LW-1:0] in_length;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          err;
    logic [AW-1:0] wr_ptr;

    modport master (
        output in_valid, in_is_copy, in_data, in_offset, in_length, out_ready,
        input  in_ready, out_valid, out_data, busy, err, wr_ptr
    );

    modport slave (
        input  in_valid, in_is_copy, in_data, in_offset, in_length, out_ready,
        output in_ready, out_valid, out_data, busy, err, wr_ptr
    );
endinterface

// File: rtl/history_buffer.sv
// LZS-decode history engine: turns literal/copy tokens into a symbol stream and
// keeps a circular window of emitted symbols in a 1-cycle synchronous-read RAM.
module history_buffer #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 11,
    parameter int unsigned LW = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    history_buffer_if.slave  bus
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [0:0] {StIdle, StCpy} state_e;

    state_e        state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] fill_q, fill_d;
    logic          err_q, err_d;
    logic [AW-1:0] src_q, src_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          rd_pend_q, rd_pend_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic          fwd_hit_q, fwd_hit_d;
    logic [DW-1:0] fwd_data_q, fwd_data_d;

    logic [DW-1:0] mem [Depth];
    logic [DW-1:0] ram_rd_q;

    logic          slot_free;
    logic          in_ready;
    logic          accept;
    logic          load;
    logic [DW-1:0] load_data;
    logic          issue;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] fetch_data;

    assign slot_free  = !out_valid_q || bus.out_ready;
    assign in_ready   = rst_n && (state_q == StIdle) && slot_free;
    assign accept     = bus.in_valid && in_ready;
    // A read that hit the address being written in the same cycle sees stale RAM data.
    assign fetch_data = fwd_hit_q ? fwd_data_q : ram_rd_q;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q && !bus.out_ready;
        out_data_d   = out_data_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        err_d        = err_q;
        src_d        = src_q;
        rem_d        = rem_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        load         = 1'b0;
        load_data    = out_data_q;
        issue        = 1'b0;
        rd_addr      = src_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!bus.in_is_copy) begin
                        load      = 1'b1;
                        load_data = bus.in_data;
                    end else if (bus.in_length == '0) begin
                        // zero-length copy is simply dropped
                    end else if (bus.in_offset == '0 || bus.in_offset > fill_q) begin
                        err_d = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        rd_addr = wr_ptr_q - bus.in_offset;
                        src_d   = rd_addr + AW'(1);
                        rem_d   = bus.in_length - LW'(1);
                        state_d = StCpy;
                    end
                end
            end
            StCpy: begin
                // Skid holds at most one word; a read is only issued when the skid
                // will be empty, so its data always has somewhere to land.
                if (skid_valid_q) begin
                    if (slot_free) begin
                        load         = 1'b1;
                        load_data    = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end else if (rd_pend_q) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_data = fetch_data;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = fetch_data;
                    end
                end
                if (rem_q != '0 && !skid_valid_d) begin
                    issue = 1'b1;
                    src_d = src_q + AW'(1);
                    rem_d = rem_q - LW'(1);
                end
                if (rem_q == '0 && !skid_valid_d) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = load_data;
            wr_ptr_d    = wr_ptr_q + AW'(1);
            if (fill_q != '1) begin
                fill_d = fill_q + AW'(1);
            end
        end

        rd_pend_d  = issue;
        fwd_hit_d  = issue && load && (rd_addr == wr_ptr_q);
        fwd_data_d = load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            err_q        <= 1'b0;
            src_q        <= '0;
            rem_q        <= '0;
            rd_pend_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            fwd_hit_q    <= 1'b0;
            fwd_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            err_q        <= err_d;
            src_q        <= src_d;
            rem_q        <= rem_d;
            rd_pend_q    <= rd_pend_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            fwd_hit_q    <= fwd_hit_d;
            fwd_data_q   <= fwd_data_d;
        end
    end

    // History RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (load) begin
            mem[wr_ptr_q] <= load_data;
        end
        ram_rd_q <= mem[rd_addr];
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q == StCpy);
    assign bus.err       = err_q;
    assign bus.wr_ptr    = wr_ptr_q;

endmodule
